scan_controller: RTL and testbench
==================================

SCAN_CONTROLLER -- requirements
Module: scan_controller

Interface
REQ-001 Parameter PW_MIN, default 100000: lowest servo pulse width in CLK cycles.
REQ-002 Parameter PW_MAX, default 200000: highest servo pulse width in CLK cycles.
REQ-003 Parameter PW_STEP, default 5000: sweep increment; PW_MAX+PW_STEP SHALL be below 2^32.
REQ-004 Parameter SETTLE_CYCLES, default 2000000: servo settle wait after each move, minimum 1.
REQ-005 CLK  in  1  single system clock, all logic on rising edge.
REQ-006 RST_N  in  1  reset, asynchronous assertion, active-low.
REQ-007 START  in  1  one-cycle request to begin a full H-then-V scan.
REQ-008 ADC_VALID  in  1  one-cycle strobe: a new 12-bit ADC sample is presented downstream this cycle.
REQ-009 pulseWidth_max_H  in  32  stored best H pulse width from the max-value register.
REQ-010 pulseWidth_max_V  in  32  stored best V pulse width from the max-value register.
REQ-011 pulseWidth_H  out  32  commanded horizontal servo pulse width.
REQ-012 pulseWidth_V  out  32  commanded vertical servo pulse width.
REQ-013 SAMPLE_EN  out  1  qualifies the compare/store path; high exactly one cycle per sweep point.
REQ-014 BUSY  out  1  high from the cycle after START acceptance until HOLD is entered.
REQ-015 DONE  out  1  high while in HOLD.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, SAMPLE, STEP, PARK, HOLD; an axis bit (H/V) SHALL select the swept output.
REQ-017 IDLE or HOLD with START=1: axis=H, pulseWidth_H<=PW_MIN, pulseWidth_V<=PW_MID ((PW_MIN+PW_MAX)/2, truncating), settle counter cleared, go SETTLE.
REQ-018 START while BUSY SHALL be ignored.
REQ-019 SETTLE SHALL count exactly SETTLE_CYCLES cycles, then go SAMPLE.
REQ-020 SAMPLE SHALL wait indefinitely for ADC_VALID; ADC_VALID outside SAMPLE SHALL be ignored.
REQ-021 In the cycle ADC_VALID=1 in SAMPLE, SAMPLE_EN SHALL be 1 (combinational AND of state and ADC_VALID), next state STEP.
REQ-022 STEP: if swept width + PW_STEP <= PW_MAX, add PW_STEP (32-bit unsigned), clear counter, go SETTLE; else go PARK.
REQ-023 PARK SHALL last one cycle and load the swept output from the matching pulseWidth_max_* input, sampled in that cycle.
REQ-024 A PARK value outside [PW_MIN, PW_MAX] (including 0, nothing stored) SHALL be replaced by PW_MID.
REQ-025 After PARK on axis H: axis=V, pulseWidth_V<=PW_MIN in the same cycle as the H park load, go SETTLE.
REQ-026 After PARK on axis V: go HOLD; both outputs SHALL then stay constant until the next accepted START.
REQ-027 Sweep point count per axis SHALL be floor((PW_MAX-PW_MIN)/PW_STEP)+1; the last point SHALL not exceed PW_MAX.
REQ-028 Outputs pulseWidth_H, pulseWidth_V, BUSY, DONE SHALL be registered.

Reset
REQ-029 RST_N low SHALL immediately force state IDLE, axis H, counter 0, pulseWidth_H=pulseWidth_V=PW_MID, BUSY=0, DONE=0, SAMPLE_EN=0.
REQ-030 Reset mid-scan SHALL abandon the scan; no PARK load occurs; release returns to IDLE awaiting START.

Structure
REQ-031 A shared package SHALL hold the state encoding, axis encoding and the PW_MID derivation.
REQ-032 One sub-module, settle_timer (load/count/expired), is natural; all else stays in scan_controller.

Verification (PW_MIN=10, PW_MAX=30, PW_STEP=10, SETTLE_CYCLES=4)
REQ-033 Reset -> both widths 20, BUSY=0, DONE=0; START -> pulseWidth_H=10, V=20, BUSY=1 next cycle.
REQ-034 ADC_VALID once per SAMPLE -> H steps 10,20,30, exactly 3 SAMPLE_EN pulses, then V sweeps 10,20,30.
REQ-035 pulseWidth_max_H=20, pulseWidth_max_V=30 at PARK -> final H=20, V=30, DONE=1, BUSY=0.
REQ-036 pulseWidth_max_H=0 at PARK -> H parks at 20; ADC_VALID during SETTLE -> no SAMPLE_EN, no step.
REQ-037 START during V sweep ignored; RST_N low mid-H-sweep -> widths 20, IDLE, no DONE after release.
REQ-038 PW_STEP=15 -> H points 10,25 only, never 40; START in HOLD -> rescan begins at H=10.

Source files
------------

// File: rtl/scan_controller_pkg.sv
// Shared types and helpers for the two-axis servo scan controller.
package scan_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_STEP   = 3'd3,
    ST_PARK   = 3'd4,
    ST_HOLD   = 3'd5
  } state_t;

  typedef enum logic {
    AXIS_H = 1'b0,
    AXIS_V = 1'b1
  } axis_t;

  localparam int unsigned PW_BITS = 32;

  // Midpoint of the sweep range; the sum is widened so it cannot wrap.
  function automatic logic [PW_BITS-1:0] pw_mid(input logic [PW_BITS-1:0] lo,
                                               input logic [PW_BITS-1:0] hi);
    logic [PW_BITS:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return sum[PW_BITS:1];
  endfunction

  function automatic logic pw_in_range(input logic [PW_BITS-1:0] val,
                                       input logic [PW_BITS-1:0] lo,
                                       input logic [PW_BITS-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/scan_controller_settle.sv
// Settle timer: cleared by i_load, advances while i_count, flags the final settle cycle.
module settle_timer
  import scan_controller_pkg::*;
#(
  parameter logic [31:0] SETTLE_CYCLES = 32'd2000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_count,
  output logic o_expired
);

  localparam logic [31:0] LAST_CNT = SETTLE_CYCLES - 32'd1;

  logic [31:0] r_count;

  // Expired during the last of SETTLE_CYCLES counting cycles, so the FSM leaves on that edge.
  assign o_expired = (r_count == LAST_CNT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_count) begin
      r_count <= o_expired ? 32'd0 : r_count + 32'd1;
    end
  end

endmodule

// File: rtl/scan_controller.sv
// Sweeps the H servo then the V servo across [PW_MIN, PW_MAX], sampling the ADC at each
// point, then parks each axis on the best stored width and holds there.
module scan_controller
  import scan_controller_pkg::*;
#(
  parameter logic [31:0] PW_MIN        = 32'd100000,
  parameter logic [31:0] PW_MAX        = 32'd200000,
  parameter logic [31:0] PW_STEP       = 32'd5000,
  parameter logic [31:0] SETTLE_CYCLES = 32'd2000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        ADC_VALID,
  input  logic [31:0] pulseWidth_max_H,
  input  logic [31:0] pulseWidth_max_V,
  output logic [31:0] pulseWidth_H,
  output logic [31:0] pulseWidth_V,
  output logic        SAMPLE_EN,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [31:0] PW_MID = pw_mid(PW_MIN, PW_MAX);

  state_t      r_state;
  state_t      w_state_next;
  axis_t       r_axis;
  axis_t       w_axis_next;
  logic [31:0] r_pw_h;
  logic [31:0] w_pw_h_next;
  logic [31:0] r_pw_v;
  logic [31:0] w_pw_v_next;
  logic        r_busy;
  logic        w_busy_next;
  logic        r_done;
  logic        w_done_next;

  logic        w_tmr_load;
  logic        w_tmr_count;
  logic        w_tmr_expired;

  logic [31:0] w_swept;
  logic [31:0] w_swept_inc;
  logic [31:0] w_park_raw;
  logic [31:0] w_park_val;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_load   (w_tmr_load),
    .i_count  (w_tmr_count),
    .o_expired(w_tmr_expired)
  );

  assign w_swept     = (r_axis == AXIS_H) ? r_pw_h : r_pw_v;
  assign w_swept_inc = w_swept + PW_STEP;
  assign w_park_raw  = (r_axis == AXIS_H) ? pulseWidth_max_H : pulseWidth_max_V;
  // A zero or out-of-range stored width means no usable maximum: fall back to centre.
  assign w_park_val  = pw_in_range(w_park_raw, PW_MIN, PW_MAX) ? w_park_raw : PW_MID;

  assign SAMPLE_EN    = (r_state == ST_SAMPLE) && ADC_VALID;
  assign pulseWidth_H = r_pw_h;
  assign pulseWidth_V = r_pw_v;
  assign BUSY         = r_busy;
  assign DONE         = r_done;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_axis  <= AXIS_H;
      r_pw_h  <= PW_MID;
      r_pw_v  <= PW_MID;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_axis  <= w_axis_next;
      r_pw_h  <= w_pw_h_next;
      r_pw_v  <= w_pw_v_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_axis_next  = r_axis;
    w_pw_h_next  = r_pw_h;
    w_pw_v_next  = r_pw_v;
    w_busy_next  = r_busy;
    w_done_next  = r_done;
    w_tmr_load   = 1'b0;
    w_tmr_count  = 1'b0;

    unique case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (START) begin
          w_axis_next  = AXIS_H;
          w_pw_h_next  = PW_MIN;
          w_pw_v_next  = PW_MID;
          w_tmr_load   = 1'b1;
          w_busy_next  = 1'b1;
          w_done_next  = 1'b0;
          w_state_next = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        w_tmr_count = 1'b1;
        if (w_tmr_expired) begin
          w_state_next = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (ADC_VALID) begin
          w_state_next = ST_STEP;
        end
      end

      ST_STEP: begin
        if (w_swept_inc <= PW_MAX) begin
          if (r_axis == AXIS_H) begin
            w_pw_h_next = w_swept_inc;
          end else begin
            w_pw_v_next = w_swept_inc;
          end
          w_tmr_load   = 1'b1;
          w_state_next = ST_SETTLE;
        end else begin
          w_state_next = ST_PARK;
        end
      end

      ST_PARK: begin
        if (r_axis == AXIS_H) begin
          w_pw_h_next  = w_park_val;
          w_axis_next  = AXIS_V;
          w_pw_v_next  = PW_MIN;
          w_tmr_load   = 1'b1;
          w_state_next = ST_SETTLE;
        end else begin
          w_pw_v_next  = w_park_val;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_state_next = ST_HOLD;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_controller.sv
// Directed bench for scan_controller: one instance with PW_STEP=10 and one with PW_STEP=15.
module tb_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        start_a, adc_a, sen_a, busy_a, done_a;
  logic [31:0] max_h_a, max_v_a, pw_h_a, pw_v_a;
  logic        start_b, adc_b, sen_b, busy_b, done_b;
  logic [31:0] max_h_b, max_v_b, pw_h_b, pw_v_b;

  int checks = 0;
  int errors = 0;

  scan_controller #(
    .PW_MIN(32'd10), .PW_MAX(32'd30), .PW_STEP(32'd10), .SETTLE_CYCLES(32'd4)
  ) dut_a (
    .CLK(clk), .RST_N(rst_n), .START(start_a), .ADC_VALID(adc_a),
    .pulseWidth_max_H(max_h_a), .pulseWidth_max_V(max_v_a),
    .pulseWidth_H(pw_h_a), .pulseWidth_V(pw_v_a),
    .SAMPLE_EN(sen_a), .BUSY(busy_a), .DONE(done_a)
  );

  scan_controller #(
    .PW_MIN(32'd10), .PW_MAX(32'd30), .PW_STEP(32'd15), .SETTLE_CYCLES(32'd4)
  ) dut_b (
    .CLK(clk), .RST_N(rst_n), .START(start_b), .ADC_VALID(adc_b),
    .pulseWidth_max_H(max_h_b), .pulseWidth_max_V(max_v_b),
    .pulseWidth_H(pw_h_b), .pulseWidth_V(pw_v_b),
    .SAMPLE_EN(sen_b), .BUSY(busy_b), .DONE(done_b)
  );

  // Record the commanded widths at every SAMPLE_EN pulse.
  int          n_a = 0;
  logic [31:0] log_h_a [64];
  logic [31:0] log_v_a [64];
  int          n_b = 0;
  logic [31:0] log_h_b [64];
  logic [31:0] log_v_b [64];
  logic [31:0] peak_b = '0;

  always @(negedge clk) begin
    if (sen_a) begin
      if (n_a < 64) begin
        log_h_a[n_a] = pw_h_a;
        log_v_a[n_a] = pw_v_a;
      end
      n_a++;
    end
    if (sen_b) begin
      if (n_b < 64) begin
        log_h_b[n_b] = pw_h_b;
        log_v_b[n_b] = pw_v_b;
      end
      n_b++;
    end
    if (pw_h_b > peak_b) peak_b = pw_h_b;
    if (pw_v_b > peak_b) peak_b = pw_v_b;
  end

  task automatic pulse_start_a();
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (done_a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_samples_a(input int target, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (n_a >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    adc_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pw_h_a !== 32'd20 || pw_v_a !== 32'd20) begin errors++;
      $display("FAIL reset_widths got H=%0d V=%0d want H=20 V=20", pw_h_a, pw_v_a); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || sen_a !== 1'b0) begin errors++;
      $display("FAIL reset_flags got busy=%b done=%b sen=%b want 0 0 0", busy_a, done_a, sen_a); end
    checks++; if (pw_h_b !== 32'd20 || pw_v_b !== 32'd20) begin errors++;
      $display("FAIL reset_widths_b got H=%0d V=%0d want 20 20", pw_h_b, pw_v_b); end
    #3 rst_n = 1'b1;
    adc_a = 1'b0;
    $display("test_reset: widths H=%0d V=%0d busy=%b done=%b", pw_h_a, pw_v_a, busy_a, done_a);
  endtask

  task automatic test_full_scan();
    logic [31:0] exp_h [6];
    logic [31:0] exp_v [6];
    bit ok;
    int base;
    exp_h = '{32'd10, 32'd20, 32'd30, 32'd20, 32'd20, 32'd20};
    exp_v = '{32'd20, 32'd20, 32'd20, 32'd10, 32'd20, 32'd30};
    max_h_a = 32'd20;
    max_v_a = 32'd30;
    adc_a = 1'b1;
    base = n_a;
    pulse_start_a();
    checks++; if (pw_h_a !== 32'd10 || pw_v_a !== 32'd20 || busy_a !== 1'b1 || done_a !== 1'b0) begin errors++;
      $display("FAIL start_accept got H=%0d V=%0d busy=%b done=%b want 10 20 1 0", pw_h_a, pw_v_a, busy_a, done_a); end
    wait_done_a(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_scan_timeout got done=0 want done=1 within 200 cycles"); end
    checks++; if (n_a - base !== 6) begin errors++;
      $display("FAIL full_scan_samples got %0d want 6", n_a - base); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (log_h_a[base+i] !== exp_h[i] || log_v_a[base+i] !== exp_v[i]) begin errors++;
        $display("FAIL sweep_point%0d got H=%0d V=%0d want H=%0d V=%0d", i, log_h_a[base+i], log_v_a[base+i], exp_h[i], exp_v[i]); end
    end
    checks++; if (pw_h_a !== 32'd20 || pw_v_a !== 32'd30 || busy_a !== 1'b0 || done_a !== 1'b1) begin errors++;
      $display("FAIL final_park got H=%0d V=%0d busy=%b done=%b want 20 30 0 1", pw_h_a, pw_v_a, busy_a, done_a); end
    max_h_a = 32'd25;
    max_v_a = 32'd15;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (pw_h_a !== 32'd20 || pw_v_a !== 32'd30 || done_a !== 1'b1 || n_a - base !== 6) begin errors++;
      $display("FAIL hold_stable got H=%0d V=%0d done=%b samples=%0d want 20 30 1 6", pw_h_a, pw_v_a, done_a, n_a - base); end
    $display("test_full_scan: samples=%0d final H=%0d V=%0d done=%b", n_a - base, pw_h_a, pw_v_a, done_a);
  endtask

  task automatic test_park_invalid();
    bit ok;
    int base;
    max_h_a = 32'd0;
    max_v_a = 32'd99;
    adc_a = 1'b0;
    base = n_a;
    pulse_start_a();
    checks++; if (pw_h_a !== 32'd10 || pw_v_a !== 32'd20 || busy_a !== 1'b1 || done_a !== 1'b0) begin errors++;
      $display("FAIL restart_from_hold got H=%0d V=%0d busy=%b done=%b want 10 20 1 0", pw_h_a, pw_v_a, busy_a, done_a); end
    adc_a = 1'b1;
    @(negedge clk);
    checks++; if (sen_a !== 1'b0) begin errors++;
      $display("FAIL settle_ignores_adc got sample_en=%b want 0", sen_a); end
    @(posedge clk); #1 adc_a = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++; if (pw_h_a !== 32'd10 || n_a !== base) begin errors++;
      $display("FAIL sample_waits got H=%0d samples=%0d want H=10 samples=0", pw_h_a, n_a - base); end
    adc_a = 1'b1;
    wait_samples_a(base + 4, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL v_sweep_timeout got samples=%0d want 4", n_a - base); end
    pulse_start_a();
    checks++; if (pw_h_a !== 32'd20 || pw_v_a !== 32'd20 || busy_a !== 1'b1) begin errors++;
      $display("FAIL start_ignored_busy got H=%0d V=%0d busy=%b want 20 20 1", pw_h_a, pw_v_a, busy_a); end
    wait_done_a(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL invalid_scan_timeout got done=0 want done=1"); end
    checks++; if (n_a - base !== 6 || pw_h_a !== 32'd20 || pw_v_a !== 32'd20) begin errors++;
      $display("FAIL invalid_park got samples=%0d H=%0d V=%0d want 6 20 20", n_a - base, pw_h_a, pw_v_a); end
    $display("test_park_invalid: samples=%0d final H=%0d V=%0d", n_a - base, pw_h_a, pw_v_a);
  endtask

  task automatic test_reset_mid_scan();
    int base;
    max_h_a = 32'd30;
    max_v_a = 32'd30;
    adc_a = 1'b1;
    base = n_a;
    pulse_start_a();
    checks++; if (pw_h_a !== 32'd10 || busy_a !== 1'b1) begin errors++;
      $display("FAIL mid_prestate got H=%0d busy=%b want 10 1", pw_h_a, busy_a); end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    checks++; if (pw_h_a !== 32'd20 || pw_v_a !== 32'd20 || busy_a !== 1'b0 || done_a !== 1'b0 || sen_a !== 1'b0) begin errors++;
      $display("FAIL async_reset got H=%0d V=%0d busy=%b done=%b sen=%b want 20 20 0 0 0", pw_h_a, pw_v_a, busy_a, done_a, sen_a); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    checks++; if (done_a !== 1'b0 || busy_a !== 1'b0 || n_a !== base || pw_h_a !== 32'd20) begin errors++;
      $display("FAIL after_reset_idle got done=%b busy=%b samples=%0d H=%0d want 0 0 0 20", done_a, busy_a, n_a - base, pw_h_a); end
    adc_a = 1'b0;
    $display("test_reset_mid_scan: H=%0d V=%0d busy=%b done=%b", pw_h_a, pw_v_a, busy_a, done_a);
  endtask

  task automatic test_step15();
    logic [31:0] exp_h [4];
    logic [31:0] exp_v [4];
    bit ok;
    exp_h = '{32'd10, 32'd25, 32'd25, 32'd25};
    exp_v = '{32'd20, 32'd20, 32'd10, 32'd25};
    max_h_b = 32'd25;
    max_v_b = 32'd10;
    adc_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    checks++; if (pw_h_b !== 32'd10 || pw_v_b !== 32'd20 || busy_b !== 1'b1) begin errors++;
      $display("FAIL step15_start got H=%0d V=%0d busy=%b want 10 20 1", pw_h_b, pw_v_b, busy_b); end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done_b) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL step15_timeout got done=0 want done=1"); end
    checks++; if (n_b !== 4) begin errors++; $display("FAIL step15_samples got %0d want 4", n_b); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (log_h_b[i] !== exp_h[i] || log_v_b[i] !== exp_v[i]) begin errors++;
        $display("FAIL step15_point%0d got H=%0d V=%0d want H=%0d V=%0d", i, log_h_b[i], log_v_b[i], exp_h[i], exp_v[i]); end
    end
    checks++; if (peak_b !== 32'd25) begin errors++; $display("FAIL step15_peak got %0d want 25", peak_b); end
    checks++; if (pw_h_b !== 32'd25 || pw_v_b !== 32'd10 || done_b !== 1'b1 || busy_b !== 1'b0) begin errors++;
      $display("FAIL step15_final got H=%0d V=%0d done=%b busy=%b want 25 10 1 0", pw_h_b, pw_v_b, done_b, busy_b); end
    $display("test_step15: samples=%0d peak=%0d final H=%0d V=%0d", n_b, peak_b, pw_h_b, pw_v_b);
  endtask

  initial begin
    start_a = 1'b0; adc_a = 1'b0; max_h_a = '0; max_v_a = '0;
    start_b = 1'b0; adc_b = 1'b0; max_h_b = '0; max_v_b = '0;
    test_reset();
    test_full_scan();
    test_park_invalid();
    test_reset_mid_scan();
    test_step15();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
